// File: rtl/tdc_arb_pkg.sv
// -----------------------------------------------------------------------------
// tdc_arb_pkg
// Shared types and default sizes for the TDC readout arbiter.
//   arb_state_t   : scheduler state (IDLE, CAPTURE, OUTPUT)
//   TDC_CHANNELS  : default number of TDC channels scanned
//   TDC_WORD_LEN  : default width of one TDC word
// -----------------------------------------------------------------------------
package tdc_arb_pkg;

    localparam int TDC_CHANNELS = 16;
    localparam int TDC_WORD_LEN = 68;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        OUTPUT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin search. Finds the first set bit of `valid`,
// scanning rr_ptr, rr_ptr+1, ..., WIDTH-1, 0, ..., rr_ptr-1.
// Reusable by any shared-resource arbiter.
// Ports:
//   valid  [WIDTH]      : request flags
//   rr_ptr [IDX_W]      : highest-priority index (must be < WIDTH)
//   found               : at least one request is set
//   index  [IDX_W]      : winning request index (0 when nothing is found)
// -----------------------------------------------------------------------------
module rr_priority_picker #(
    parameter  int WIDTH = 16,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    // One extra bit so rr_ptr + offset cannot overflow before the wrap.
    localparam logic [IDX_W:0] WRAP = WIDTH[IDX_W:0];

    logic [IDX_W:0] cand;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment; otherwise synthesis infers a latch.
        found = 1'b0;
        index = '0;
        cand  = '0;
        // Scan from the farthest offset down to offset 0 so the nearest hit
        // to rr_ptr is the last assignment and therefore wins.
        for (int k = WIDTH - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (cand >= WRAP) begin
                cand = cand - WRAP;
            end
            if (valid[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                index = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tdc_readout_arbiter.sv
// -----------------------------------------------------------------------------
// tdc_readout_arbiter
// Round-robin readout scheduler for the TDC output path. Scans the channel
// valid flags, drives the external mux select, captures the selected word,
// acks the channel and presents the word on a valid/ready handshake.
//
// Optional feature: define TDC_ARB_GRANT_CNT_EN to add o_grant_count, a
// 16-bit saturating count of completed downstream handshakes.
//
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   i_valid   [WIDTH]   : per-channel word pending (held until acked)
//   o_ack     [WIDTH]   : one-hot, one-cycle ack to the captured channel
//   o_sel     [IDX_W]   : registered mux select
//   i_data    [DL]      : mux output, combinational from o_sel
//   o_data    [DL]      : captured word, stable while o_valid
//   o_channel [IDX_W]   : channel index of o_data
//   o_valid / i_ready   : downstream handshake
//   o_busy              : scheduler is not idle
//   o_grant_count [16]  : (TDC_ARB_GRANT_CNT_EN only) handshake count
//
// A word sitting in OUTPUT when reset asserts is dropped: its channel has
// already been acked, so that word is lost by design.
// -----------------------------------------------------------------------------
module tdc_readout_arbiter
    import tdc_arb_pkg::*;
#(
    parameter  int WIDTH       = TDC_CHANNELS,
    parameter  int DATA_LENGTH = TDC_WORD_LEN,
    localparam int IDX_W       = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       i_valid,
    output logic [WIDTH-1:0]       o_ack,
    output logic [IDX_W-1:0]       o_sel,
    input  logic [DATA_LENGTH-1:0] i_data,
    output logic [DATA_LENGTH-1:0] o_data,
    output logic [IDX_W-1:0]       o_channel,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_busy
`ifdef TDC_ARB_GRANT_CNT_EN
    ,
    output logic [15:0]            o_grant_count
`endif
);

    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_HOT = {{(WIDTH - 1){1'b0}}, 1'b1};

    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] next_ptr;
    logic             found;
    logic [IDX_W-1:0] pick;

    rr_priority_picker #(
        .WIDTH (WIDTH)
    ) u_picker (
        .valid  (i_valid),
        .rr_ptr (rr_ptr),
        .found  (found),
        .index  (pick)
    );

    // The channel just served becomes lowest priority on the next scan.
    assign next_ptr = (o_channel == LAST_CH) ? '0 : o_channel + 1'b1;

    assign o_busy = (state != IDLE);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            o_sel     <= '0;
            o_data    <= '0;
            o_channel <= '0;
            o_valid   <= 1'b0;
            o_ack     <= '0;
        end else begin
            o_ack <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        o_sel <= pick;
                        state <= CAPTURE;
                    end
                end
                // One cycle for the external mux to settle on the new o_sel.
                CAPTURE: begin
                    o_data    <= i_data;
                    o_channel <= o_sel;
                    o_valid   <= 1'b1;
                    o_ack     <= ONE_HOT << o_sel;
                    state     <= OUTPUT;
                end
                OUTPUT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        rr_ptr  <= next_ptr;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef TDC_ARB_GRANT_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_grant_count <= '0;
        end else if (o_valid && i_ready && (o_grant_count != 16'hFFFF)) begin
            o_grant_count <= o_grant_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tdc_readout_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tdc_readout_arbiter
// Two arbiters (WIDTH=16 and WIDTH=10) driven by emulated TDC channels.
// A transaction-level reference model predicts every output each cycle;
// directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_tdc_readout_arbiter;

    localparam int DL = 68;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // Channel emulation: index 0 -> 16-channel DUT, index 1 -> 10-channel DUT
    logic [15:0]   pend  [2];
    logic [DL-1:0] words [2][16];
    bit            rdy   [2];
    int            timer [2][16];
    int            rearm [2];      // 0: never re-raise, >0: fixed delay, <0: random
    bit            arrivals [2];

    // 16-channel DUT
    logic [15:0]   v16, ack16;
    logic [3:0]    sel16, ch16;
    logic [DL-1:0] d16_in, d16_out;
    logic          val16, busy16, rdy16;
    // 10-channel DUT
    logic [9:0]    v10, ack10;
    logic [3:0]    sel10, ch10;
    logic [DL-1:0] d10_in, d10_out;
    logic          val10, busy10, rdy10;
`ifdef TDC_ARB_GRANT_CNT_EN
    logic [15:0]   gc16, gc10;
`endif

    assign v16    = pend[0];
    assign v10    = pend[1][9:0];
    assign rdy16  = rdy[0];
    assign rdy10  = rdy[1];
    assign d16_in = words[0][sel16];
    assign d10_in = words[1][sel10];

    tdc_readout_arbiter #(.WIDTH(16), .DATA_LENGTH(DL)) u_dut16 (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_valid   (v16),
        .o_ack     (ack16),
        .o_sel     (sel16),
        .i_data    (d16_in),
        .o_data    (d16_out),
        .o_channel (ch16),
        .o_valid   (val16),
        .i_ready   (rdy16),
        .o_busy    (busy16)
`ifdef TDC_ARB_GRANT_CNT_EN
        ,
        .o_grant_count (gc16)
`endif
    );

    tdc_readout_arbiter #(.WIDTH(10), .DATA_LENGTH(DL)) u_dut10 (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_valid   (v10),
        .o_ack     (ack10),
        .o_sel     (sel10),
        .i_data    (d10_in),
        .o_data    (d10_out),
        .o_channel (ch10),
        .o_valid   (val10),
        .i_ready   (rdy10),
        .o_busy    (busy10)
`ifdef TDC_ARB_GRANT_CNT_EN
        ,
        .o_grant_count (gc10)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [DL-1:0] act, input logic [DL-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DL-1:0] rand_word();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[DL-1:0];
    endfunction

    // ---------------- reference model (transaction level) ----------------
    // A granted channel is presented one cycle after its select is issued;
    // a presented word leaves on the first cycle ready is high.
    int            m_rr    [2];
    int            m_sel   [2];
    int            m_chan  [2];
    bit            m_valid [2];
    bit            m_grant [2];   // select issued, word not captured yet
    logic [DL-1:0] m_data  [2];
    logic [15:0]   m_ack   [2];
    int            hs      [2];

    function automatic int width_of(input int u);
        return (u == 0) ? 16 : 10;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_rr[u] = 0;  m_sel[u] = 0;  m_chan[u] = 0;
            m_valid[u] = 1'b0;  m_grant[u] = 1'b0;
            m_data[u] = '0;  m_ack[u] = '0;  hs[u] = 0;
        end
    endtask

    // Predict the outputs after the coming rising edge from current inputs.
    task automatic model_step(input int u);
        int          w;
        logic [15:0] nack;
        w    = width_of(u);
        nack = '0;
        if (m_valid[u]) begin
            if (rdy[u]) begin
                m_valid[u] = 1'b0;
                m_rr[u]    = (m_chan[u] + 1) % w;
                hs[u]++;
            end
        end else if (m_grant[u]) begin
            m_data[u]     = words[u][m_sel[u]];
            m_chan[u]     = m_sel[u];
            m_valid[u]    = 1'b1;
            nack[m_sel[u]] = 1'b1;
            m_grant[u]    = 1'b0;
        end else begin
            for (int k = 0; k < w; k++) begin
                int c;
                c = (m_rr[u] + k) % w;
                if (pend[u][c]) begin
                    m_sel[u]   = c;
                    m_grant[u] = 1'b1;
                    break;
                end
            end
        end
        m_ack[u] = nack;
    endtask

    task automatic compare();
        check("u16.valid",   DL'(val16),   DL'(m_valid[0]));
        check("u16.busy",    DL'(busy16),  DL'(m_grant[0] | m_valid[0]));
        check("u16.sel",     DL'(sel16),   DL'(m_sel[0]));
        check("u16.ack",     DL'(ack16),   DL'(m_ack[0]));
        check("u16.data",    d16_out,      m_data[0]);
        check("u16.channel", DL'(ch16),    DL'(m_chan[0]));
        check("u10.valid",   DL'(val10),   DL'(m_valid[1]));
        check("u10.busy",    DL'(busy10),  DL'(m_grant[1] | m_valid[1]));
        check("u10.sel",     DL'(sel10),   DL'(m_sel[1]));
        check("u10.ack",     DL'(ack10),   DL'(m_ack[1]));
        check("u10.data",    d10_out,      m_data[1]);
        check("u10.channel", DL'(ch10),    DL'(m_chan[1]));
        check("u10.sel_range", DL'(sel10 <= 4'd9), DL'(1'b1));
`ifdef TDC_ARB_GRANT_CNT_EN
        check("u16.grant_count", DL'(gc16), DL'((hs[0] > 65535) ? 65535 : hs[0]));
        check("u10.grant_count", DL'(gc10), DL'((hs[1] > 65535) ? 65535 : hs[1]));
`endif
    endtask

    // Channels drop their flag on ack and optionally re-raise later.
    task automatic react(input int u);
        int w;
        w = width_of(u);
        for (int c = 0; c < w; c++) begin
            if (m_ack[u][c]) begin
                pend[u][c]  = 1'b0;
                timer[u][c] = (rearm[u] < 0) ? int'($urandom_range(1, 6)) : rearm[u];
            end else if (timer[u][c] > 0) begin
                timer[u][c]--;
                if (timer[u][c] == 0) begin
                    pend[u][c]  = 1'b1;
                    words[u][c] = rand_word();
                end
            end else if (arrivals[u] && !pend[u][c] && ($urandom_range(0, 7) == 0)) begin
                pend[u][c]  = 1'b1;
                words[u][c] = rand_word();
            end
        end
    endtask

    // Inputs are set at the falling edge; outputs are compared at the next one.
    task automatic cycle();
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare();
        react(0);
        react(1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        for (int u = 0; u < 2; u++) begin
            pend[u] = '0;  rdy[u] = 1'b0;  rearm[u] = 0;  arrivals[u] = 1'b0;
            for (int c = 0; c < 16; c++) timer[u][c] = 0;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    int order [32];
    int n;

    initial begin
        for (int u = 0; u < 2; u++)
            for (int c = 0; c < 16; c++) words[u][c] = rand_word();
        do_reset();

        // Reset values
        check("reset.valid",   DL'(val16),  DL'(0));
        check("reset.sel",     DL'(sel16),  DL'(0));
        check("reset.ack",     DL'(ack16),  DL'(0));
        check("reset.data",    d16_out,     DL'(0));
        check("reset.channel", DL'(ch16),   DL'(0));
        check("reset.busy",    DL'(busy16), DL'(0));

        // Single request on channel 4
        pend[0] = 16'h0010;  words[0][4] = 68'hA5;  rdy[0] = 1'b1;
        cycle();
        check("single.sel",  DL'(sel16),  DL'(4));
        check("single.busy", DL'(busy16), DL'(1));
        check("single.pin_model_sel", DL'(m_sel[0]), DL'(4));
        cycle();
        check("single.valid",   DL'(val16), DL'(1));
        check("single.data",    d16_out,    68'hA5);
        check("single.channel", DL'(ch16),  DL'(4));
        check("single.ack",     DL'(ack16), DL'(16'h0010));
        check("single.pin_model_ack", DL'(m_ack[0]), DL'(16'h0010));
        cycle();
        check("single.valid_drop", DL'(val16), DL'(0));
        check("single.ack_drop",   DL'(ack16), DL'(0));

        // Fairness: all channels requesting, re-raise 2 cycles after ack
        do_reset();
        rearm[0] = 2;  rdy[0] = 1'b1;  pend[0] = 16'hFFFF;
        n = 0;
        for (int cyc = 0; cyc < 200 && n < 17; cyc++) begin
            cycle();
            if (val16 && rdy[0]) begin
                order[n] = int'(ch16);
                n++;
            end
        end
        check("fair.grants", DL'(n), DL'(17));
        for (int k = 0; k < n; k++) check("fair.order", DL'(order[k]), DL'(k % 16));

`ifdef TDC_ARB_GRANT_CNT_EN
        // Five handshakes at one word per three cycles
        do_reset();
        rearm[0] = 2;  rdy[0] = 1'b1;  pend[0] = 16'hFFFF;
        repeat (15) cycle();
        check("gcnt.five", DL'(gc16), DL'(5));
`endif

        // Backpressure on channel 8
        do_reset();
        pend[0] = 16'h0100;  words[0][8] = 68'h1_2345_6789_ABCD_EF01;
        cycle();
        cycle();
        check("bp.valid",   DL'(val16), DL'(1));
        check("bp.channel", DL'(ch16),  DL'(8));
        repeat (10) begin
            rdy[0] = 1'b0;
            cycle();
            check("bp.hold_valid", DL'(val16), DL'(1));
            check("bp.hold_data",  d16_out,    68'h1_2345_6789_ABCD_EF01);
            check("bp.no_ack",     DL'(ack16), DL'(0));
            check("bp.hold_sel",   DL'(sel16), DL'(8));
        end
        rdy[0] = 1'b1;
        cycle();
        check("bp.release", DL'(val16), DL'(0));

        // Wrap on the 10-channel instance: serve 9, then 2 beats 9
        do_reset();
        rdy[1] = 1'b1;  pend[1] = 16'h0200;
        for (int cyc = 0; cyc < 10 && hs[1] < 1; cyc++) cycle();
        check("wrap.first_served", DL'(hs[1]), DL'(1));
        pend[1] = 16'h0204;
        n = -1;
        for (int cyc = 0; cyc < 10 && n < 0; cyc++) begin
            cycle();
            if (val10) n = int'(ch10);
        end
        check("wrap.next_channel", DL'(n), DL'(2));

        // Reset while a word is presented
        do_reset();
        pend[0] = 16'h0020;
        cycle();
        cycle();
        check("rst.valid_before", DL'(val16), DL'(1));
        #2 reset_n = 1'b0;
        #1;
        check("rst.valid", DL'(val16),  DL'(0));
        check("rst.ack",   DL'(ack16),  DL'(0));
        check("rst.sel",   DL'(sel16),  DL'(0));
        check("rst.busy",  DL'(busy16), DL'(0));
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        pend[0] = 16'h0001;
        cycle();
        check("rst.rescan_busy", DL'(busy16), DL'(1));
        cycle();
        check("rst.rescan_valid",   DL'(val16), DL'(1));
        check("rst.rescan_channel", DL'(ch16),  DL'(0));
        check("rst.rescan_ack",     DL'(ack16), DL'(16'h0001));
        rdy[0] = 1'b1;
        cycle();
        check("rst.rescan_done", DL'(val16), DL'(0));

        // Randomized traffic with random backpressure on both instances
        do_reset();
        for (int u = 0; u < 2; u++) begin
            rearm[u] = -1;
            arrivals[u] = 1'b1;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rdy[0] = ($urandom_range(0, 3) != 0);
            rdy[1] = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
